// File: rtl/control_option_bank_pkg.sv
// Shared constants for the ZX-Uno option register bank.
// Holds the default register addresses, the control register bit layout,
// the pending FSM state encodings and a helper that builds the control
// register read word.
package control_option_bank_pkg;

  // Default ZX-Uno register addresses
  localparam logic [7:0] DEVOPTIONS = 8'h0E;
  localparam logic [7:0] BANK_CTRL  = 8'h0D;

  // Control register bit positions
  localparam int CTRL_DEFER = 0;
  localparam int CTRL_LOCK  = 1;

  // Pending FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Control register read image: {pending, 5'b0, lock, defer}
  function automatic logic [7:0] ctrl_word(input logic pending,
                                           input logic lock,
                                           input logic defer);
    return {pending, 5'b00000, lock, defer};
  endfunction

endpackage

// File: rtl/control_option_bank_option_reg_slot.sv
// One option register: a shadow byte written through a bit mask, a live
// byte loaded from the shadow on commit, and a one-cycle change flag.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   wr        - accepted write to this register this cycle
//   commit    - copy shadow into live this cycle
//   din       - write data
//   shadow    - current shadow value (read-back)
//   live      - committed option value
//   changed   - high for one cycle after a commit that altered live
module option_reg_slot #(
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter logic [7:0] MASK      = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       commit,
  input  logic [7:0] din,
  output logic [7:0] shadow,
  output logic [7:0] live,
  output logic       changed
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= RESET_VAL;
      live    <= RESET_VAL;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      // Masked bits never move away from their reset value.
      if (wr)
        shadow <= (shadow & ~MASK) | (din & MASK);
      // On a coincident write, live takes the pre-write shadow.
      if (commit) begin
        live    <= shadow;
        changed <= (live != shadow);
      end
    end
  end

endmodule

// File: rtl/control_option_bank.sv
// Bank of NREGS shadow/live option registers on the ZX-Uno register bus,
// with a control register (DEFER, sticky LOCK, pending status) and a
// two-state pending FSM that commits shadows to live values either on the
// cycle after a write or on apply_stb when deferred.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   zxuno_addr             - register address
//   zxuno_regrd/regwr      - read / write strobes
//   din                    - write data
//   apply_stb              - commit opportunity when DEFER=1
//   dout, oe_n             - combinational read data and output enable
//   opts                   - live option values, register i at [8i+7:8i]
//   changed                - per-register one-cycle change pulse
//   pending                - uncommitted shadow writes exist
module control_option_bank
  import control_option_bank_pkg::*;
#(
  parameter int                 NREGS     = 2,
  parameter logic [7:0]         BASE_ADDR = DEVOPTIONS,
  parameter logic [7:0]         CTRL_ADDR = BANK_CTRL,
  parameter logic [NREGS*8-1:0] RESET_VAL = '0,
  parameter logic [NREGS*8-1:0] WRMASK    = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         zxuno_addr,
  input  logic               zxuno_regrd,
  input  logic               zxuno_regwr,
  input  logic [7:0]         din,
  input  logic               apply_stb,
  output logic [7:0]         dout,
  output logic               oe_n,
  output logic [NREGS*8-1:0] opts,
  output logic [NREGS-1:0]   changed,
  output logic               pending
);

  logic [0:0]       state;
  logic             defer;
  logic             lock;
  logic [NREGS-1:0] hit;
  logic [NREGS-1:0] wr_sel;
  logic [7:0]       shadow [NREGS];
  logic             opt_wr;
  logic             ctrl_hit;
  logic             commit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NREGS; i++)
      if (zxuno_addr == 8'(BASE_ADDR + i))
        hit[i] = 1'b1;
  end

  assign ctrl_hit = (zxuno_addr == CTRL_ADDR);
  assign wr_sel   = hit & {NREGS{zxuno_regwr && !lock}};
  assign opt_wr   = |wr_sel;
  assign pending  = (state == ST_PEND);
  // Without DEFER a pending write commits on the very next cycle.
  assign commit   = pending && (!defer || apply_stb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else if (opt_wr)
      state <= ST_PEND;
    else if (commit)
      state <= ST_IDLE;
  end

  // Once LOCK is set the whole control register is frozen until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      defer <= 1'b0;
      lock  <= 1'b0;
    end else if (zxuno_regwr && ctrl_hit && !lock) begin
      defer <= din[CTRL_DEFER];
      lock  <= din[CTRL_LOCK];
    end
  end

  always_comb begin
    dout = 8'hFF;
    oe_n = 1'b1;
    if (zxuno_regrd) begin
      if (ctrl_hit) begin
        dout = ctrl_word(pending, lock, defer);
        oe_n = 1'b0;
      end
      for (int i = 0; i < NREGS; i++)
        if (hit[i]) begin
          dout = shadow[i];
          oe_n = 1'b0;
        end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_slot
    option_reg_slot #(
      .RESET_VAL(RESET_VAL[8*g +: 8]),
      .MASK     (WRMASK[8*g +: 8])
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .wr     (wr_sel[g]),
      .commit (commit),
      .din    (din),
      .shadow (shadow[g]),
      .live   (opts[8*g +: 8]),
      .changed(changed[g])
    );
  end

endmodule

// File: tb/tb_control_option_bank.sv
// Directed testbench for control_option_bank (NREGS=2, WRMASK=16'h1FFF).
// A table of per-cycle stimulus rows with expected outputs observed before
// that cycle's rising edge, followed by hand-written reset sequences.
module tb_control_option_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  zxuno_addr = 8'h00;
  logic        zxuno_regrd = 1'b0;
  logic        zxuno_regwr = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        apply_stb = 1'b0;
  logic [7:0]  dout;
  logic        oe_n;
  logic [15:0] opts;
  logic [1:0]  changed;
  logic        pending;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  control_option_bank #(
    .NREGS    (2),
    .BASE_ADDR(8'h0E),
    .CTRL_ADDR(8'h0D),
    .RESET_VAL(16'h0000),
    .WRMASK   (16'h1FFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .zxuno_addr (zxuno_addr),
    .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr),
    .din        (din),
    .apply_stb  (apply_stb),
    .dout       (dout),
    .oe_n       (oe_n),
    .opts       (opts),
    .changed    (changed),
    .pending    (pending)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        ap;
    logic [7:0]  edout;
    logic        eoe;
    logic [15:0] eopts;
    logic        epend;
    logic [1:0]  echg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic rd, input logic [7:0] addr,
                     input logic [7:0] data, input logic ap,
                     input logic [7:0] edout, input logic eoe,
                     input logic [15:0] eopts, input logic epend,
                     input logic [1:0] echg);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.data = data; v.ap = ap;
    v.edout = edout; v.eoe = eoe; v.eopts = eopts; v.epend = epend;
    v.echg = echg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [7:0] addr,
                       input logic [7:0] data, input logic ap);
    zxuno_regwr = wr;
    zxuno_regrd = rd;
    zxuno_addr  = addr;
    din         = data;
    apply_stb   = ap;
  endtask

  initial begin
    //   wr rd addr   din   ap  dout  oe  opts      pend chg
    add(0, 1, 8'h0E, 8'h00, 0, 8'h00, 0, 16'h0000, 0, 2'b00); // reset state
    add(1, 0, 8'h0E, 8'hA5, 0, 8'hFF, 1, 16'h0000, 0, 2'b00);
    add(0, 1, 8'h0E, 8'h00, 0, 8'hA5, 0, 16'h0000, 1, 2'b00);
    add(0, 1, 8'h0D, 8'h00, 0, 8'h00, 0, 16'h00A5, 0, 2'b01);
    add(1, 0, 8'h0F, 8'hFF, 0, 8'hFF, 1, 16'h00A5, 0, 2'b00);
    add(0, 1, 8'h0F, 8'h00, 0, 8'h1F, 0, 16'h00A5, 1, 2'b00);
    add(0, 1, 8'h0F, 8'h00, 0, 8'h1F, 0, 16'h1FA5, 0, 2'b10);
    add(1, 0, 8'h0D, 8'h01, 0, 8'hFF, 1, 16'h1FA5, 0, 2'b00); // DEFER=1
    add(1, 0, 8'h0E, 8'h3C, 0, 8'hFF, 1, 16'h1FA5, 0, 2'b00);
    add(0, 1, 8'h0D, 8'h00, 0, 8'h81, 0, 16'h1FA5, 1, 2'b00);
    add(0, 1, 8'h0D, 8'h00, 0, 8'h81, 0, 16'h1FA5, 1, 2'b00);
    add(0, 1, 8'h0D, 8'h00, 1, 8'h81, 0, 16'h1FA5, 1, 2'b00); // apply
    add(0, 1, 8'h0D, 8'h00, 0, 8'h01, 0, 16'h1F3C, 0, 2'b01);
    add(0, 1, 8'h0E, 8'h00, 1, 8'h3C, 0, 16'h1F3C, 0, 2'b00); // apply in IDLE
    add(0, 1, 8'h0E, 8'h00, 0, 8'h3C, 0, 16'h1F3C, 0, 2'b00);
    add(1, 0, 8'h0E, 8'h11, 0, 8'hFF, 1, 16'h1F3C, 0, 2'b00);
    add(1, 0, 8'h0E, 8'h22, 1, 8'hFF, 1, 16'h1F3C, 1, 2'b00); // write + commit
    add(0, 1, 8'h0E, 8'h00, 0, 8'h22, 0, 16'h1F11, 1, 2'b01);
    add(0, 1, 8'h0E, 8'h00, 1, 8'h22, 0, 16'h1F11, 1, 2'b00);
    add(0, 1, 8'h0D, 8'h00, 0, 8'h01, 0, 16'h1F22, 0, 2'b01);
    add(1, 0, 8'h0E, 8'h40, 0, 8'hFF, 1, 16'h1F22, 0, 2'b00);
    add(1, 0, 8'h0D, 8'h00, 0, 8'hFF, 1, 16'h1F22, 1, 2'b00); // clear DEFER
    add(0, 1, 8'h0D, 8'h00, 0, 8'h80, 0, 16'h1F22, 1, 2'b00);
    add(0, 1, 8'h0D, 8'h00, 0, 8'h00, 0, 16'h1F40, 0, 2'b01);
    add(1, 0, 8'h0E, 8'h40, 0, 8'hFF, 1, 16'h1F40, 0, 2'b00); // same value
    add(0, 1, 8'h0E, 8'h00, 0, 8'h40, 0, 16'h1F40, 1, 2'b00);
    add(0, 1, 8'h0E, 8'h00, 0, 8'h40, 0, 16'h1F40, 0, 2'b00);
    add(1, 0, 8'h10, 8'hAB, 0, 8'hFF, 1, 16'h1F40, 0, 2'b00); // foreign addr
    add(0, 1, 8'h10, 8'h00, 0, 8'hFF, 1, 16'h1F40, 0, 2'b00);
    add(0, 1, 8'h0C, 8'h00, 0, 8'hFF, 1, 16'h1F40, 0, 2'b00);
    add(1, 0, 8'h0D, 8'h02, 0, 8'hFF, 1, 16'h1F40, 0, 2'b00); // LOCK
    add(1, 0, 8'h0E, 8'h77, 0, 8'hFF, 1, 16'h1F40, 0, 2'b00);
    add(1, 0, 8'h0D, 8'h00, 0, 8'hFF, 1, 16'h1F40, 0, 2'b00);
    add(0, 1, 8'h0D, 8'h00, 0, 8'h02, 0, 16'h1F40, 0, 2'b00);
    add(0, 1, 8'h0E, 8'h00, 0, 8'h40, 0, 16'h1F40, 0, 2'b00);
    add(1, 0, 8'h0D, 8'h01, 0, 8'hFF, 1, 16'h1F40, 0, 2'b00);
    add(0, 1, 8'h0D, 8'h00, 0, 8'h02, 0, 16'h1F40, 0, 2'b00);

    // Asynchronous reset assertion mid-cycle, checked before any edge
    #2 rst = 1'b1;
    #1;
    chk("rst_opts", 32'(opts), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_changed", 32'(changed), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].ap);
      #2;
      chk($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].edout));
      chk($sformatf("v%0d_oe_n", i), 32'(oe_n), 32'(vecs[i].eoe));
      chk($sformatf("v%0d_opts", i), 32'(opts), 32'(vecs[i].eopts));
      chk($sformatf("v%0d_pending", i), 32'(pending), 32'(vecs[i].epend));
      chk($sformatf("v%0d_changed", i), 32'(changed), 32'(vecs[i].echg));
    end

    // LOCK holds until reset; reset mid-cycle clears it without a clock edge
    @(negedge clk);
    drive(0, 1, 8'h0D, 8'h00, 0);
    #2 chk("lock_before_rst", 32'(dout), 32'h02);
    rst = 1'b1;
    #1;
    chk("lock_after_rst", 32'(dout), 32'h00);
    chk("lock_rst_opts", 32'(opts), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during PEND with DEFER=1 discards the write
    @(negedge clk);
    drive(1, 0, 8'h0D, 8'h01, 0);
    @(negedge clk);
    drive(1, 0, 8'h0E, 8'h55, 0);
    @(negedge clk);
    drive(0, 1, 8'h0E, 8'h00, 0);
    #2;
    chk("pend_shadow", 32'(dout), 32'h55);
    chk("pend_before_rst", 32'(pending), 32'h1);
    rst = 1'b1;
    #1;
    chk("pend_rst_pending", 32'(pending), 32'h0);
    chk("pend_rst_opts", 32'(opts), 32'h0);
    chk("pend_rst_shadow", 32'(dout), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(0, 1, 8'h0D, 8'h00, 1);
      #2;
      chk($sformatf("post_rst%0d_changed", c), 32'(changed), 32'h0);
      chk($sformatf("post_rst%0d_opts", c), 32'(opts), 32'h0);
      chk($sformatf("post_rst%0d_ctrl", c), 32'(dout), 32'h00);
    end
    @(negedge clk);
    drive(0, 0, 8'h00, 8'h00, 0);
    #2 chk("final_changed", 32'(changed), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
